// File: rtl/card_auth_responder.sv
// Card-side LAYR responder: APDU bytes in, AUTH_INIT/AUTH/GET_ID over a shared AES core and nonce source, response bytes out.
// Latency: rx_ready drops the cycle after rx_last; every aes_start/nonce_req is one cycle after entering its issue state.
// Backpressure: rx is valid/ready (ready only while idle); tx is valid/ready with tx_data/tx_last held while tx_ready is low.
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   psk, card_id                quasi-static pre-shared key and plaintext identity
//   rx_valid/ready/data/last    inbound command frame: CLA, INS, payload (MSB first)
//   tx_valid/ready/data/last    outbound response: 16-byte block or 1 status byte
//   aes_*                       request/response to the shared AES-128 ECB core
//   nonce_req, nonce(_valid)    request/response to the nonce generator
//   authenticated, busy         session flag and "not idle" indicator
module card_auth_responder #(
    parameter logic [7:0] CLA        = 8'h80,
    parameter logic [7:0] STATUS_OK  = 8'h90,
    parameter logic [7:0] STATUS_ERR = 8'hFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] psk,
    input  logic [127:0] card_id,
    input  logic         rx_valid,
    output logic         rx_ready,
    input  logic [7:0]   rx_data,
    input  logic         rx_last,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_last,
    output logic         aes_start,
    output logic         aes_mode,
    output logic [127:0] aes_key,
    output logic [127:0] aes_block_in,
    input  logic [127:0] aes_block_out,
    input  logic         aes_done,
    output logic         nonce_req,
    input  logic [63:0]  nonce,
    input  logic         nonce_valid,
    output logic         authenticated,
    output logic         busy
);

    localparam logic [7:0] INS_AUTH_INIT = 8'h10;
    localparam logic [7:0] INS_AUTH      = 8'h11;
    localparam logic [7:0] INS_GET_ID    = 8'h12;

    typedef enum logic [3:0] {
        ST_RX, ST_DISPATCH, ST_NONCE, ST_NONCE_WAIT, ST_ENC_RC, ST_ENC_RC_WAIT,
        ST_DEC_AUTH, ST_DEC_AUTH_WAIT, ST_DERIVE, ST_DERIVE_WAIT,
        ST_ENC_ID, ST_ENC_ID_WAIT, ST_TX_BLOCK, ST_TX_STATUS
    } state_t;

    state_t         state;
    logic [4:0]     rx_cnt;      // saturates at 19 so overlong frames stay overlong
    logic [7:0]     cla_q;
    logic [7:0]     ins_q;
    logic [127:0]   payload;
    logic [63:0]    rc;
    logic [63:0]    rt;
    logic [127:0]   session_key;
    logic [127:0]   blk;         // outgoing block, shifted left one byte per transfer
    logic [3:0]     tx_idx;
    logic           chal_valid;

    logic cla_ok, is_init, is_auth, is_getid, frame_ok, keep_auth;

    assign cla_ok   = (cla_q == CLA);
    assign is_init  = (rx_cnt == 5'd2)  && (ins_q == INS_AUTH_INIT);
    assign is_auth  = (rx_cnt == 5'd18) && (ins_q == INS_AUTH);
    assign is_getid = (rx_cnt == 5'd2)  && (ins_q == INS_GET_ID);
    assign frame_ok = cla_ok && (is_init || is_auth || is_getid);
    // A bad CLA or a malformed GET_ID must not tear down an existing session.
    // A one-byte frame has no INS, so a stale ins_q must not count.
    assign keep_auth = !cla_ok || ((rx_cnt >= 5'd2) && (ins_q == INS_GET_ID));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RX;
            rx_cnt        <= 5'd0;
            cla_q         <= 8'h00;
            ins_q         <= 8'h00;
            payload       <= '0;
            rc            <= '0;
            rt            <= '0;
            session_key   <= '0;
            blk           <= '0;
            tx_idx        <= 4'd0;
            chal_valid    <= 1'b0;
            authenticated <= 1'b0;
            rx_ready      <= 1'b1;
            busy          <= 1'b0;
            tx_valid      <= 1'b0;
            tx_data       <= 8'h00;
            tx_last       <= 1'b0;
            aes_start     <= 1'b0;
            aes_mode      <= 1'b0;
            aes_key       <= '0;
            aes_block_in  <= '0;
            nonce_req     <= 1'b0;
        end else begin
            aes_start <= 1'b0;
            nonce_req <= 1'b0;
            case (state)
                ST_RX: begin
                    if (rx_valid && rx_ready) begin
                        if (rx_cnt == 5'd0) cla_q <= rx_data;
                        if (rx_cnt == 5'd1) ins_q <= rx_data;
                        if (rx_cnt >= 5'd2 && rx_cnt <= 5'd17) payload <= {payload[119:0], rx_data};
                        if (rx_cnt != 5'd19) rx_cnt <= rx_cnt + 5'd1;
                        if (rx_last) begin
                            state    <= ST_DISPATCH;
                            rx_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                ST_DISPATCH: begin
                    rx_cnt <= 5'd0;
                    if (!frame_ok) begin
                        chal_valid <= 1'b0;
                        if (!keep_auth) authenticated <= 1'b0;
                        tx_data <= STATUS_ERR;
                        state   <= ST_TX_STATUS;
                    end else if (is_init) begin
                        authenticated <= 1'b0;
                        chal_valid    <= 1'b0;
                        state         <= ST_NONCE;
                    end else if (is_auth) begin
                        if (!chal_valid) begin
                            authenticated <= 1'b0;
                            tx_data       <= STATUS_ERR;
                            state         <= ST_TX_STATUS;
                        end else begin
                            chal_valid <= 1'b0;   // challenge is single-use
                            state      <= ST_DEC_AUTH;
                        end
                    end else begin
                        if (!authenticated) begin
                            chal_valid <= 1'b0;
                            tx_data    <= STATUS_ERR;
                            state      <= ST_TX_STATUS;
                        end else begin
                            state <= ST_ENC_ID;
                        end
                    end
                end
                ST_NONCE: begin
                    nonce_req <= 1'b1;
                    state     <= ST_NONCE_WAIT;
                end
                ST_NONCE_WAIT: begin
                    if (nonce_valid) begin
                        rc    <= nonce;
                        state <= ST_ENC_RC;
                    end
                end
                ST_ENC_RC: begin
                    aes_start    <= 1'b1;
                    aes_mode     <= 1'b0;
                    aes_key      <= psk;
                    aes_block_in <= {rc, 64'h0};
                    state        <= ST_ENC_RC_WAIT;
                end
                ST_ENC_RC_WAIT: begin
                    if (aes_done) begin
                        blk        <= aes_block_out;
                        chal_valid <= 1'b1;
                        state      <= ST_TX_BLOCK;
                    end
                end
                ST_DEC_AUTH: begin
                    aes_start    <= 1'b1;
                    aes_mode     <= 1'b1;
                    aes_key      <= psk;
                    aes_block_in <= payload;
                    state        <= ST_DEC_AUTH_WAIT;
                end
                ST_DEC_AUTH_WAIT: begin
                    if (aes_done) begin
                        if (aes_block_out[63:0] == rc) begin
                            rt    <= aes_block_out[127:64];
                            state <= ST_DERIVE;
                        end else begin
                            authenticated <= 1'b0;
                            tx_data       <= STATUS_ERR;
                            state         <= ST_TX_STATUS;
                        end
                    end
                end
                ST_DERIVE: begin
                    aes_start    <= 1'b1;
                    aes_mode     <= 1'b0;
                    aes_key      <= psk;
                    aes_block_in <= {rc, rt};
                    state        <= ST_DERIVE_WAIT;
                end
                ST_DERIVE_WAIT: begin
                    if (aes_done) begin
                        session_key   <= aes_block_out;
                        authenticated <= 1'b1;
                        tx_data       <= STATUS_OK;
                        state         <= ST_TX_STATUS;
                    end
                end
                ST_ENC_ID: begin
                    aes_start    <= 1'b1;
                    aes_mode     <= 1'b0;
                    aes_key      <= session_key;
                    aes_block_in <= card_id;
                    state        <= ST_ENC_ID_WAIT;
                end
                ST_ENC_ID_WAIT: begin
                    if (aes_done) begin
                        blk   <= aes_block_out;
                        state <= ST_TX_BLOCK;
                    end
                end
                ST_TX_BLOCK: begin
                    // tx_valid low here means this is the entry cycle: load byte 0.
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= blk[127:120];
                        tx_last  <= 1'b0;
                        tx_idx   <= 4'd0;
                        blk      <= {blk[119:0], 8'h00};
                    end else if (tx_ready) begin
                        if (tx_idx == 4'd15) begin
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            rx_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_RX;
                        end else begin
                            tx_data <= blk[127:120];
                            blk     <= {blk[119:0], 8'h00};
                            tx_idx  <= tx_idx + 4'd1;
                            tx_last <= (tx_idx == 4'd14);
                        end
                    end
                end
                ST_TX_STATUS: begin
                    // Status byte was placed on tx_data when this state was chosen.
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_last  <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        rx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_RX;
                    end
                end
                default: begin
                    state    <= ST_RX;
                    rx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
